rv32_alu_arbiter: RTL and testbench

RV32_ALU_ARBITER -- requirements
Module: rv32_alu_arbiter

---
 rtl/rv32_alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_rv32_alu_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu_arbiter.sv
// Two-requester round-robin front end for a shared, registered RV32 ALU.
// One operation in flight at a time: IDLE -> ISSUE -> CAPT -> RESP -> IDLE.
module rv32_alu_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [3:0]        r0_opsel,
  input  logic [31:0]       r0_s1,
  input  logic [31:0]       r0_s2,
  input  logic [31:0]       r0_pc,
  input  logic [31:0]       r0_code,
  input  logic [TAG_W-1:0]  r0_tag,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [31:0]       r0_rsp_data,
  output logic [TAG_W-1:0]  r0_rsp_tag,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [3:0]        r1_opsel,
  input  logic [31:0]       r1_s1,
  input  logic [31:0]       r1_s2,
  input  logic [31:0]       r1_pc,
  input  logic [31:0]       r1_code,
  input  logic [TAG_W-1:0]  r1_tag,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [31:0]       r1_rsp_data,
  output logic [TAG_W-1:0]  r1_rsp_tag,
  output logic              alu_enable,
  output logic [3:0]        alu_opsel,
  output logic [31:0]       alu_s1,
  output logic [31:0]       alu_s2,
  output logic [31:0]       alu_pc,
  output logic [31:0]       alu_code,
  input  logic [31:0]       alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_r;
  logic               last_grant_r;
  logic               owner_r;
  logic [3:0]         opsel_r;
  logic [31:0]        s1_r;
  logic [31:0]        s2_r;
  logic [31:0]        pc_r;
  logic [31:0]        code_r;
  logic [TAG_W-1:0]   tag_r;
  logic [31:0]        result_r;
  logic [CNT_W-1:0]   op_count_r;
  logic               grant_s;
  logic               accept_s;
  logic               rsp_done_s;

  // Grant selection and request handshake; ready is gated by reset so nothing is accepted while held.
  always_comb begin
    grant_s = 1'b0;
    if (r0_req_valid && r1_req_valid) begin
      grant_s = ~last_grant_r;
    end else if (r1_req_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    r0_req_ready = rst_n && (state_r == IDLE) && r0_req_valid && !grant_s;
    r1_req_ready = rst_n && (state_r == IDLE) && r1_req_valid && grant_s;
    accept_s     = r0_req_ready || r1_req_ready;
    rsp_done_s   = (state_r == RESP) && (owner_r ? r1_rsp_ready : r0_rsp_ready);
  end

  // Transaction FSM with operand, result and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      opsel_r      <= 4'd0;
      s1_r         <= 32'd0;
      s2_r         <= 32'd0;
      pc_r         <= 32'd0;
      code_r       <= 32'd0;
      tag_r        <= {TAG_W{1'b0}};
      result_r     <= 32'd0;
      op_count_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            opsel_r      <= grant_s ? r1_opsel : r0_opsel;
            s1_r         <= grant_s ? r1_s1    : r0_s1;
            s2_r         <= grant_s ? r1_s2    : r0_s2;
            pc_r         <= grant_s ? r1_pc    : r0_pc;
            code_r       <= grant_s ? r1_code  : r0_code;
            tag_r        <= grant_s ? r1_tag   : r0_tag;
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          state_r <= CAPT;
        end
        CAPT: begin
          result_r <= alu_result;
          state_r  <= RESP;
        end
        RESP: begin
          if (rsp_done_s) begin
            op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            state_r    <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // All remaining outputs are straight decodes of registered state.
  assign alu_enable   = (state_r == ISSUE);
  assign alu_opsel    = opsel_r;
  assign alu_s1       = s1_r;
  assign alu_s2       = s2_r;
  assign alu_pc       = pc_r;
  assign alu_code     = code_r;
  assign busy         = (state_r != IDLE);
  assign r0_rsp_valid = (state_r == RESP) && !owner_r;
  assign r1_rsp_valid = (state_r == RESP) && owner_r;
  assign r0_rsp_data  = result_r;
  assign r1_rsp_data  = result_r;
  assign r0_rsp_tag   = tag_r;
  assign r1_rsp_tag   = tag_r;
  assign op_count     = op_count_r;

endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// Scoreboard bench for rv32_alu_arbiter with a behavioural registered ALU.
module tb_rv32_alu_arbiter;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0_req_valid = 1'b0, r1_req_valid = 1'b0;
  logic r0_req_ready, r1_req_ready;
  logic [3:0] r0_opsel = 4'd0, r1_opsel = 4'd0;
  logic [31:0] r0_s1 = 32'd0, r0_s2 = 32'd0, r0_pc = 32'd0, r0_code = 32'd0;
  logic [31:0] r1_s1 = 32'd0, r1_s2 = 32'd0, r1_pc = 32'd0, r1_code = 32'd0;
  logic [TAG_W-1:0] r0_tag = 4'd0, r1_tag = 4'd0;
  logic r0_rsp_valid, r1_rsp_valid;
  logic r0_rsp_ready = 1'b1, r1_rsp_ready = 1'b1;
  logic [31:0] r0_rsp_data, r1_rsp_data;
  logic [TAG_W-1:0] r0_rsp_tag, r1_rsp_tag;
  logic alu_enable;
  logic [3:0] alu_opsel;
  logic [31:0] alu_s1, alu_s2, alu_pc, alu_code;
  logic [31:0] alu_result = 32'd0;
  logic busy;
  logic [CNT_W-1:0] op_count;

  typedef struct {
    logic             id;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic last_m = 1'b1;

  rv32_alu_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_opsel(r0_opsel),
    .r0_s1(r0_s1), .r0_s2(r0_s2), .r0_pc(r0_pc), .r0_code(r0_code), .r0_tag(r0_tag),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data),
    .r0_rsp_tag(r0_rsp_tag),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_opsel(r1_opsel),
    .r1_s1(r1_s1), .r1_s2(r1_s2), .r1_pc(r1_pc), .r1_code(r1_code), .r1_tag(r1_tag),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data),
    .r1_rsp_tag(r1_rsp_tag),
    .alu_enable(alu_enable), .alu_opsel(alu_opsel), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_pc(alu_pc), .alu_code(alu_code), .alu_result(alu_result),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc,
                                            input logic [31:0] code);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd14:   return code & 32'hFFFF_F000;
      4'd15:   return pc + (code & 32'hFFFF_F000);
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU: result registered on enable, held otherwise.
  always @(posedge clk) begin
    if (alu_enable) alu_result <= alu_model(alu_opsel, alu_s1, alu_s2, alu_pc, alu_code);
  end

  // Monitor: grant model, scoreboard push on acceptance, pop/compare on response.
  initial begin
    exp_t e;
    logic g, e0, e1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        last_m = 1'b1;
      end else begin
        if (r0_req_valid && r1_req_valid) g = ~last_m;
        else g = r1_req_valid;
        e0 = !busy && r0_req_valid && !g;
        e1 = !busy && r1_req_valid && g;
        checks++;
        if ({r1_req_ready, r0_req_ready} !== {e1, e0}) begin
          failures++;
          $display("FAIL grant t=%0t got=%b exp=%b", $time, {r1_req_ready, r0_req_ready}, {e1, e0});
        end
        if (r0_req_valid && r0_req_ready) begin
          q.push_back('{1'b0, alu_model(r0_opsel, r0_s1, r0_s2, r0_pc, r0_code), r0_tag});
          last_m = 1'b0;
        end
        if (r1_req_valid && r1_req_ready) begin
          q.push_back('{1'b1, alu_model(r1_opsel, r1_s1, r1_s2, r1_pc, r1_code), r1_tag});
          last_m = 1'b1;
        end
        if ((r0_rsp_valid && r0_rsp_ready) || (r1_rsp_valid && r1_rsp_ready)) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t got=unexpected response exp=none", $time);
          end else begin
            e = q.pop_front();
            if (r1_rsp_valid !== e.id || (e.id ? r1_rsp_data : r0_rsp_data) !== e.data ||
                (e.id ? r1_rsp_tag : r0_rsp_tag) !== e.tag) begin
              failures++;
              $display("FAIL scoreboard t=%0t got=id%0b/%h/%h exp=id%0b/%h/%h", $time, r1_rsp_valid,
                       e.id ? r1_rsp_data : r0_rsp_data, e.id ? r1_rsp_tag : r0_rsp_tag,
                       e.id, e.data, e.tag);
            end
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    tick;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic n, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc, input logic [31:0] code,
                      input logic [TAG_W-1:0] tg, output bit ok);
    tick;
    if (n == 1'b0) begin
      r0_opsel = op; r0_s1 = a; r0_s2 = b; r0_pc = pc; r0_code = code; r0_tag = tg;
      r0_req_valid = 1'b1;
    end else begin
      r1_opsel = op; r1_s1 = a; r1_s2 = b; r1_pc = pc; r1_code = code; r1_tag = tg;
      r1_req_valid = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((n ? r1_req_ready : r0_req_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic n, output logic [31:0] d, output logic [TAG_W-1:0] t,
                          output bit ok);
    ok = 1'b0;
    d = 32'd0;
    t = 4'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((n ? r1_rsp_valid : r0_rsp_valid) === 1'b1) begin
        d = n ? r1_rsp_data : r0_rsp_data;
        t = n ? r1_rsp_tag : r0_rsp_tag;
        ok = 1'b1;
        break;
      end
    end
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    r0_req_valid = 1'b1;
    r1_req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, alu_enable, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, alu_enable, busy});
    end
    checks++;
    if ({op_count, alu_s1, alu_code, r0_rsp_data, r1_rsp_tag} !== 116'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0", op_count, alu_s1, alu_code,
               r0_rsp_data, r1_rsp_tag);
    end
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    tick;
    r0_opsel = 4'd0; r0_s1 = 32'd5; r0_s2 = 32'd7; r0_tag = 4'd3; r0_req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (r0_req_ready !== 1'b1) begin
      failures++; $display("FAIL single_ready got=%b exp=1", r0_req_ready);
    end
    tick;
    r0_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_enable, alu_opsel, alu_s1, alu_s2} !== {1'b1, 4'd0, 32'd5, 32'd7}) begin
      failures++;
      $display("FAIL single_issue got=%b/%h/%h/%h exp=1/0/5/7", alu_enable, alu_opsel, alu_s1, alu_s2);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({alu_enable, r0_rsp_valid, busy} !== 3'b001) begin
      failures++; $display("FAIL single_capt got=%b exp=001", {alu_enable, r0_rsp_valid, busy});
    end
    tick;
    @(negedge clk);
    checks++;
    if ({r0_rsp_valid, r0_rsp_data, r0_rsp_tag} !== {1'b1, 32'd12, 4'd3}) begin
      failures++;
      $display("FAIL single_rsp got=%b/%h/%h exp=1/0000000c/3", r0_rsp_valid, r0_rsp_data, r0_rsp_tag);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({busy, op_count} !== {1'b0, 16'd1}) begin
      failures++; $display("FAIL single_count got=%b/%0d exp=0/1", busy, op_count);
    end
  endtask

  task automatic test_round_robin;
    bit found;
    do_reset;
    r0_opsel = 4'd1; r0_s1 = 32'd10;   r0_s2 = 32'd3;    r0_tag = 4'd1;
    r1_opsel = 4'd2; r1_s1 = 32'hF0;   r1_s2 = 32'h3C;   r1_tag = 4'd2;
    r0_req_valid = 1'b1;
    r1_req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      found = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (r0_req_ready || r1_req_ready) begin
          found = 1'b1;
          break;
        end
      end
      checks++;
      if (!found || r1_req_ready !== k[0]) begin
        failures++;
        $display("FAIL rr_order k=%0d got=%b%b exp_r1=%0b", k, r1_req_ready, r0_req_ready, k[0]);
      end
    end
    tick;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    repeat (6) tick;
    @(negedge clk);
    checks++;
    if (op_count !== 16'd8 || q.size() != 0) begin
      failures++; $display("FAIL rr_drain got=%0d/%0d exp=8/0", op_count, q.size());
    end
  endtask

  task automatic test_rsp_stall;
    bit ok;
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    r1_rsp_ready = 1'b0;
    send(1'b1, 4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0, 32'd0, 4'd9, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_accept got=timeout exp=ready"); end
    r0_opsel = 4'd3; r0_s1 = 32'h12; r0_s2 = 32'h21; r0_tag = 4'd5; r0_req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (r1_rsp_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_rsp got=timeout exp=rsp_valid"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({r1_rsp_valid, r1_rsp_data, r1_rsp_tag, alu_enable, r0_req_ready, op_count} !==
          {1'b1, 32'hF00F_F00F, 4'd9, 1'b0, 1'b0, 16'd8}) begin
        failures++;
        $display("FAIL stall_hold i=%0d got=%b/%h/%h/%b/%b/%0d exp=1/f00ff00f/9/0/0/8", i,
                 r1_rsp_valid, r1_rsp_data, r1_rsp_tag, alu_enable, r0_req_ready, op_count);
      end
      @(negedge clk);
    end
    tick;
    r1_rsp_ready = 1'b1;
    @(negedge clk);
    tick;
    @(negedge clk);
    checks++;
    if ({r0_req_ready, op_count} !== {1'b1, 16'd9}) begin
      failures++; $display("FAIL stall_next got=%b/%0d exp=1/9", r0_req_ready, op_count);
    end
    tick;
    r0_req_valid = 1'b0;
    wait_rsp(1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 32'h33 || t !== 4'd5) begin
      failures++; $display("FAIL stall_r0 got=%0b/%h/%h exp=1/00000033/5", ok, d, t);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    send(1'b0, 4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd1, ok);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, alu_enable, r0_rsp_valid, alu_s1, op_count, r0_rsp_data} !== 83'd0) begin
      failures++;
      $display("FAIL midreset_async got=%b%b%b/%h/%0d/%h exp=0", busy, alu_enable, r0_rsp_valid,
               alu_s1, op_count, r0_rsp_data);
    end
    @(negedge clk);
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (r0_rsp_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL midreset_abandon got=response exp=none"); end
    send(1'b0, 4'd1, 32'd100, 32'd1, 32'd0, 32'd0, 4'd2, ok);
    wait_rsp(1'b0, d, t, ok);
    @(negedge clk);
    checks++;
    if (!ok || d !== 32'd99 || t !== 4'd2 || op_count !== 16'd1) begin
      failures++;
      $display("FAIL midreset_next got=%0b/%0d/%h/%0d exp=1/99/2/1", ok, d, t, op_count);
    end
  endtask

  task automatic test_opcode;
    bit ok;
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    send(1'b0, 4'd14, 32'd0, 32'd0, 32'd0, 32'hABCD_E000, 4'd6, ok);
    wait_rsp(1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 32'hABCD_E000 || t !== 4'd6) begin
      failures++; $display("FAIL op14 got=%0b/%h/%h exp=1/abcde000/6", ok, d, t);
    end
    send(1'b1, 4'd15, 32'd0, 32'd0, 32'h100, 32'hABCD_E000, 4'd7, ok);
    wait_rsp(1'b1, d, t, ok);
    checks++;
    if (!ok || d !== 32'hABCD_E100 || t !== 4'd7) begin
      failures++; $display("FAIL op15 got=%0b/%h/%h exp=1/abcde100/7", ok, d, t);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [31:0] d;
    logic [TAG_W-1:0] t;
    tick;
    force dut.op_count_r = 16'hFFFF;
    #1;
    release dut.op_count_r;
    @(negedge clk);
    checks++;
    if (op_count !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preload got=%h exp=ffff", op_count);
    end
    send(1'b1, 4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd4, ok);
    wait_rsp(1'b1, d, t, ok);
    @(negedge clk);
    checks++;
    if (!ok || op_count !== 16'h0000) begin
      failures++; $display("FAIL wrap got=%0b/%h exp=1/0000", ok, op_count);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_rsp_stall;
    test_reset_mid;
    test_opcode;
    test_wrap;
    repeat (2) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
